code_lock_ctrl: RTL and testbench
=================================

CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, number of BCD digits per code (2..4).
REQ-002 SHALL have parameter CODE, default 16'h2606, secret code. The first digit entered is CODE[4*CODE_LEN-1 -: 4].
REQ-003 SHALL have parameter MAX_FAIL, default 3, number of consecutive failed codes that triggers lockout.
REQ-004 SHALL have parameter FAIL_CYCLES, default 25_000_000, duration of the fail indication in clk cycles.
REQ-005 SHALL have parameter LOCK_CYCLES, default 250_000_000, duration of lockout in clk cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port digit_in, input, 4 bits: BCD digit from SW[3:0], quasi-static.
REQ-009 SHALL have port enter, input, 1 bit: active-high level from an inverted KEY, asynchronous to clk.
REQ-010 SHALL have port clear, input, 1 bit: synchronous, active-high abort/relock request.
REQ-011 SHALL have port unlocked, output, 1 bit: the correct code was accepted (drives LEDR[0]).
REQ-012 SHALL have port fail, output, 1 bit: the fail indication window is active.
REQ-013 SHALL have port locked_out, output, 1 bit: lockout window is active.
REQ-014 SHALL have port digit_idx, output, 2 bits: index of the next digit expected (for HEX display).
REQ-015 SHALL have port fail_count, output, 2 bits: consecutive failed codes.

Function
REQ-016 enter SHALL pass through a 2-flop synchronizer. A press is defined as a rising edge of the synchronized signal: if enter is first sampled high at edge N, the press takes effect at edge N+2.
REQ-017 The state machine SHALL have the states ENTRY, UNLOCKED, FAIL and LOCKOUT.
REQ-018 In ENTRY, each press SHALL compare digit_in with code digit digit_idx, set a sticky mismatch flag on inequality or on digit_in > 9, and increment digit_idx.
REQ-019 A press at digit_idx == CODE_LEN-1 SHALL reset digit_idx to 0. The next state SHALL be UNLOCKED if no mismatch occurred (including the final digit) and FAIL otherwise. fail_count SHALL increment (saturating at MAX_FAIL) on the transition to FAIL.
REQ-020 The mismatch outcome SHALL NOT be observable before the final digit is entered. unlocked and fail SHALL remain 0 during entry.
REQ-021 In ENTRY, clear SHALL reset digit_idx and the mismatch flag, and SHALL NOT change fail_count. If clear and a press occur in the same cycle, clear SHALL win and the press SHALL be discarded.
REQ-022 UNLOCKED SHALL hold unlocked=1 and fail_count=0 until clear. On clear it SHALL go to ENTRY with digit_idx=0.
REQ-023 FAIL SHALL assert fail for exactly FAIL_CYCLES cycles. On expiry it SHALL go to LOCKOUT if fail_count == MAX_FAIL, otherwise to ENTRY.
REQ-024 LOCKOUT SHALL assert locked_out for exactly LOCK_CYCLES cycles, then go to ENTRY with fail_count=0.
REQ-025 In UNLOCKED, FAIL and LOCKOUT, presses SHALL be ignored and SHALL NOT be queued. In FAIL and LOCKOUT, clear SHALL also be ignored.
REQ-026 A single down-counter SHALL be shared by FAIL and LOCKOUT, sized as $clog2(max(FAIL_CYCLES, LOCK_CYCLES)+1) bits, and loaded on entry to each state.
REQ-027 All outputs SHALL be registered or decoded directly from state and registers, with no combinational path from any input.

Reset
REQ-028 Reset SHALL force state=ENTRY; digit_idx, fail_count, the mismatch flag, the counter and all synchronizer/edge flops to 0; and unlocked, fail and locked_out to 0.
REQ-029 Reset asserted mid-operation SHALL abort immediately, with no press recorded.
REQ-030 A press SHALL NOT be detected on reset release even if enter is already held high.

Structure
REQ-031 A shared package code_lock_pkg SHALL hold the state enum type and the BCD digit width constant.
REQ-032 The sub-module key_edge SHALL hold the synchronizer and the rising-edge detector. The remainder SHALL be in code_lock_ctrl.

Verification
Common setup: FAIL_CYCLES=4, LOCK_CYCLES=8 for all scenarios.
REQ-033 Press 2,6,0,6 -> unlocked=1 at edge N+2 of the 4th press. Then clear -> unlocked=0, digit_idx=0.
REQ-034 Press 2,6,0,7 -> fail=1 for exactly 4 cycles, then fail_count=1 and state ENTRY.
REQ-035 Three wrong codes -> after the third fail window, locked_out=1 for exactly 8 cycles. Presses during lockout are ignored. Afterwards fail_count=0.
REQ-036 Press 2,6, then clear and a press in the same cycle -> digit_idx=0. Then 2,6,0,6 -> unlocked=1.
REQ-037 Hold enter high for 20 cycles -> exactly one press registered. Hold enter high through reset release -> no press registered.
REQ-038 Press digit_in=4'hA as the first digit, then 6,0,6 -> fail=1.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the keypad code lock: FSM state encoding,
// BCD digit width and code-digit lookup.
package code_lock_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_FAIL     = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  // Digit idx of a code whose first-entered digit sits in the top nibble.
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [15:0] code,
                                                    input int          len,
                                                    input logic [1:0]  idx);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == len - 1 - int'(idx)) d = code[4*i +: 4];
    end
    return d;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer and rising-edge detector for the asynchronous enter key.
// A press needs the key seen low after reset, so a key held through reset release is not a press.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic       low_q;
  logic [1:0] warm;

  // warm marks when sync2 carries a real sample rather than its reset value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      low_q <= 1'b0;
      warm  <= 2'b00;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
      low_q <= warm[1] & ~sync2;
    end
  end

  assign press = sync2 & low_q;

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: digit entry with deferred mismatch reporting, timed fail
// indication and lockout after repeated failures.
//
// state       | meaning
// ST_ENTRY    | collecting digits, mismatch held silently until the last digit
// ST_UNLOCKED | correct code accepted, waiting for clear
// ST_FAIL     | wrong code, fail shown for FAIL_CYCLES
// ST_LOCKOUT  | too many failures, locked_out shown for LOCK_CYCLES
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int          CODE_LEN    = 4,
  parameter logic [15:0] CODE        = 16'h2606,
  parameter int          MAX_FAIL    = 3,
  parameter int          FAIL_CYCLES = 25_000_000,
  parameter int          LOCK_CYCLES = 250_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               enter,
  input  logic               clear,
  output logic               unlocked,
  output logic               fail,
  output logic               locked_out,
  output logic [1:0]         digit_idx,
  output logic [1:0]         fail_count
);

  localparam int MAX_CYC = (FAIL_CYCLES > LOCK_CYCLES) ? FAIL_CYCLES : LOCK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] FAIL_LOAD = CNT_W'(FAIL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       LAST_IDX  = 2'(CODE_LEN - 1);
  localparam logic [1:0]       FAIL_MAX  = 2'(MAX_FAIL);

  state_t             state;
  logic               mismatch;
  logic [CNT_W-1:0]   cnt;
  logic               press;
  logic [DIGIT_W-1:0] exp_digit;
  logic               digit_bad;

  key_edge u_key_edge (
    .clk   (clk),
    .reset (reset),
    .d     (enter),
    .press (press)
  );

  assign exp_digit = code_digit(CODE, CODE_LEN, digit_idx);
  assign digit_bad = (digit_in > 4'd9) || (digit_in != exp_digit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_ENTRY;
      digit_idx  <= 2'd0;
      fail_count <= 2'd0;
      mismatch   <= 1'b0;
      cnt        <= '0;
      unlocked   <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      case (state)
        ST_ENTRY: begin
          if (clear) begin
            digit_idx <= 2'd0;
            mismatch  <= 1'b0;
          end else if (press) begin
            if (digit_idx == LAST_IDX) begin
              digit_idx <= 2'd0;
              mismatch  <= 1'b0;
              if (mismatch || digit_bad) begin
                state <= ST_FAIL;
                fail  <= 1'b1;
                cnt   <= FAIL_LOAD;
                if (fail_count < FAIL_MAX) fail_count <= fail_count + 2'd1;
              end else begin
                state      <= ST_UNLOCKED;
                unlocked   <= 1'b1;
                fail_count <= 2'd0;
              end
            end else begin
              digit_idx <= digit_idx + 2'd1;
              mismatch  <= mismatch | digit_bad;
            end
          end
        end

        ST_UNLOCKED: begin
          if (clear) begin
            state     <= ST_ENTRY;
            unlocked  <= 1'b0;
            digit_idx <= 2'd0;
            mismatch  <= 1'b0;
          end
        end

        ST_FAIL: begin
          if (cnt == '0) begin
            fail <= 1'b0;
            if (fail_count >= FAIL_MAX) begin
              state      <= ST_LOCKOUT;
              locked_out <= 1'b1;
              cnt        <= LOCK_LOAD;
            end else begin
              state <= ST_ENTRY;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_LOCKOUT: begin
          if (cnt == '0) begin
            state      <= ST_ENTRY;
            locked_out <= 1'b0;
            fail_count <= 2'd0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: state <= ST_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with short fail/lockout windows;
// expected values are hand-derived from the press-to-effect timing.
module tb_code_lock_ctrl;
  import code_lock_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_in;
  logic       enter;
  logic       clear;
  logic       unlocked;
  logic       fail;
  logic       locked_out;
  logic [1:0] digit_idx;
  logic [1:0] fail_count;

  int errors = 0;
  int checks = 0;
  int n;

  code_lock_ctrl #(
    .CODE_LEN    (4),
    .CODE        (16'h2606),
    .MAX_FAIL    (3),
    .FAIL_CYCLES (4),
    .LOCK_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_in   (digit_in),
    .enter      (enter),
    .clear      (clear),
    .unlocked   (unlocked),
    .fail       (fail),
    .locked_out (locked_out),
    .digit_idx  (digit_idx),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the press takes effect, enter left high.
  task automatic press(input logic [3:0] d);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    digit_in = d;
    enter    = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic count_fail(output int cnt);
    cnt = 0;
    while (fail && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; clear = 1'b0; digit_in = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_unlocked", 32'(unlocked), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_locked_out", 32'(locked_out), 0);
    chk("rst_digit_idx", 32'(digit_idx), 0);
    chk("rst_fail_count", 32'(fail_count), 0);
    reset = 1'b0;

    // correct code with press latency on the final digit
    press(4'd2);
    chk("idx_after_1", 32'(digit_idx), 1);
    press(4'd6);
    press(4'd0);
    chk("idx_after_3", 32'(digit_idx), 3);
    chk("no_unlock_during_entry", 32'(unlocked), 0);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    digit_in = 4'd6;
    enter    = 1'b1;
    @(negedge clk);
    chk("unlock_at_N", 32'(unlocked), 0);
    @(negedge clk);
    chk("unlock_at_N1", 32'(unlocked), 0);
    @(negedge clk);
    chk("unlock_at_N2", 32'(unlocked), 1);
    chk("unlock_idx", 32'(digit_idx), 0);
    press(4'd2);
    chk("unlocked_ignores_press", 32'(digit_idx), 0);
    chk("unlocked_holds", 32'(unlocked), 1);
    do_clear();
    chk("clear_unlocked", 32'(unlocked), 0);
    chk("clear_idx", 32'(digit_idx), 0);
    chk("clear_state", 32'(dut.state), 32'(ST_ENTRY));

    // one wrong code: 4-cycle fail window, no early fail indication
    press(4'd2); press(4'd6); press(4'd0);
    chk("no_fail_during_entry", 32'(fail), 0);
    press(4'd7);
    count_fail(n);
    chk("fail_window_1", 32'(n), 4);
    chk("fail_count_1", 32'(fail_count), 1);
    chk("fail1_state", 32'(dut.state), 32'(ST_ENTRY));

    // two more wrong codes lead to lockout
    press(4'd1); press(4'd1); press(4'd1); press(4'd1);
    count_fail(n);
    chk("fail_window_2", 32'(n), 4);
    chk("fail_count_2", 32'(fail_count), 2);
    chk("no_lockout_at_2", 32'(locked_out), 0);
    press(4'd9); press(4'd6); press(4'd0); press(4'd6);
    chk("fail_count_3", 32'(fail_count), 3);
    count_fail(n);
    chk("fail_window_3", 32'(n), 4);
    n = 0;
    while (locked_out && n < 100) begin
      enter = (n == 2 || n == 3);
      n++;
      @(negedge clk);
    end
    enter = 1'b0;
    chk("lockout_window", 32'(n), 8);
    chk("lockout_fail_count", 32'(fail_count), 0);
    repeat (3) @(negedge clk);
    chk("lockout_press_ignored", 32'(digit_idx), 0);
    chk("lockout_state", 32'(dut.state), 32'(ST_ENTRY));

    // clear beats a simultaneous press and keeps fail_count
    press(4'd3); press(4'd3); press(4'd3); press(4'd3);
    count_fail(n);
    chk("fail_count_pre_clear", 32'(fail_count), 1);
    press(4'd2); press(4'd6);
    chk("idx_before_clear", 32'(digit_idx), 2);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    digit_in = 4'd0;
    enter    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_wins_idx", 32'(digit_idx), 0);
    chk("clear_keeps_fail_count", 32'(fail_count), 1);
    press(4'd2); press(4'd6); press(4'd0); press(4'd6);
    chk("unlock_after_clear", 32'(unlocked), 1);
    chk("unlock_zeroes_fail_count", 32'(fail_count), 0);
    do_clear();

    // a long hold is a single press
    enter = 1'b0;
    repeat (3) @(negedge clk);
    digit_in = 4'd2;
    enter    = 1'b1;
    repeat (20) @(negedge clk);
    chk("hold_one_press", 32'(digit_idx), 1);

    // reset mid-press aborts; enter held through release is not a press
    enter = 1'b0;
    repeat (3) @(negedge clk);
    digit_in = 4'd6;
    enter    = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset_idx", 32'(digit_idx), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_through_reset_idx", 32'(digit_idx), 0);
    chk("held_through_reset_unl", 32'(unlocked), 0);
    press(4'd2);
    chk("press_after_reset", 32'(digit_idx), 1);
    do_clear();

    // non-BCD digit is always a mismatch
    press(4'hA); press(4'd6); press(4'd0);
    chk("nonbcd_no_early_fail", 32'(fail), 0);
    press(4'd6);
    chk("nonbcd_fail", 32'(fail), 1);
    chk("nonbcd_not_unlocked", 32'(unlocked), 0);
    count_fail(n);
    chk("nonbcd_fail_window", 32'(n), 4);
    chk("nonbcd_fail_count", 32'(fail_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
